// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue and an in-order,
// variable-latency memory port; squashes stale responses after a redirect.
module stage_if_prefetch #(
    parameter int unsigned      BUS_W    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 1,
    parameter logic [BUS_W-1:0] RESET_PC = '0,
    parameter logic [BUS_W-1:0] NOP_INST = BUS_W'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     jumpEn,
    input  logic [BUS_W-1:0]         jumpAddr,
    output logic                     memReqValid,
    input  logic                     memReqReady,
    output logic [BUS_W-1:0]         memReqAddr,
    input  logic                     memRspValid,
    input  logic [BUS_W-1:0]         memRspData,
    output logic [BUS_W-1:0]         pcOut,
    output logic [BUS_W-1:0]         pcPlusOut,
    output logic [BUS_W-1:0]         instOut,
    output logic                     instValidOut,
    output logic [$clog2(DEPTH):0]   bufCount
);

    localparam int unsigned      PW     = $clog2(DEPTH);
    localparam int unsigned      CW     = PW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [BUS_W-1:0] STEP   = BUS_W'(PC_STEP);

    logic [BUS_W-1:0] fetch_pc_q, fetch_pc_d, req_pc;
    logic [BUS_W-1:0] slot_pc_q   [DEPTH];
    logic [BUS_W-1:0] slot_inst_q [DEPTH];
    logic [DEPTH-1:0] slot_fill_q;

    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] head_ptr_q, head_ptr_d;
    logic [PW-1:0] alloc_idx;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW:0]   inflight;

    logic accept, rsp_take, rsp_drop, deq;

    logic [BUS_W-1:0] pc_out_q, pc_out_d;
    logic [BUS_W-1:0] pc_plus_q, pc_plus_d;
    logic [BUS_W-1:0] inst_out_q, inst_out_d;
    logic             valid_out_q, valid_out_d;

    always_comb begin
        req_pc      = jumpEn ? jumpAddr : fetch_pc_q;
        // outstanding = unfilled queue slots plus responses still to be squashed
        inflight    = {1'b0, alloc_cnt_q} - {1'b0, fill_cnt_q}
                    + {1'b0, drop_cnt_q};
        memReqValid = (alloc_cnt_q < DEPTH_C) && (inflight < {1'b0, DEPTH_C});
        accept      = memReqValid && memReqReady;
        deq         = slot_fill_q[head_ptr_q] && (alloc_cnt_q != '0)
                    && !jumpEn && !flush && !stall;
        rsp_take    = memRspValid && (drop_cnt_q == '0) && !jumpEn;
        rsp_drop    = memRspValid && (drop_cnt_q != '0);
        fetch_pc_d  = accept ? req_pc + STEP : req_pc;
        alloc_idx   = jumpEn ? '0 : alloc_ptr_q;

        if (jumpEn) begin
            alloc_ptr_d = PW'(accept);
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            alloc_cnt_d = CW'(accept);
            fill_cnt_d  = '0;
            drop_cnt_d  = inflight[CW-1:0] - CW'(memRspValid);
        end else begin
            alloc_ptr_d = alloc_ptr_q + PW'(accept);
            fill_ptr_d  = fill_ptr_q + PW'(rsp_take);
            head_ptr_d  = head_ptr_q + PW'(deq);
            alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(deq);
            fill_cnt_d  = fill_cnt_q + CW'(rsp_take) - CW'(deq);
            drop_cnt_d  = drop_cnt_q - CW'(rsp_drop);
        end
    end

    always_comb begin
        pc_out_d    = pc_out_q;
        pc_plus_d   = pc_plus_q;
        inst_out_d  = inst_out_q;
        valid_out_d = valid_out_q;
        if (deq) begin
            pc_out_d    = slot_pc_q[head_ptr_q];
            pc_plus_d   = slot_pc_q[head_ptr_q] + STEP;
            inst_out_d  = slot_inst_q[head_ptr_q];
            valid_out_d = 1'b1;
        end else if (jumpEn || flush || !stall) begin
            pc_out_d    = '0;
            pc_plus_d   = '0;
            inst_out_d  = NOP_INST;
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            fill_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            slot_fill_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_pc_q[i]   <= '0;
                slot_inst_q[i] <= '0;
            end
            pc_out_q    <= '0;
            pc_plus_q   <= '0;
            inst_out_q  <= NOP_INST;
            valid_out_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            pc_out_q    <= pc_out_d;
            pc_plus_q   <= pc_plus_d;
            inst_out_q  <= inst_out_d;
            valid_out_q <= valid_out_d;
            if (jumpEn) begin
                slot_fill_q <= '0;
            end else begin
                if (deq) slot_fill_q[head_ptr_q] <= 1'b0;
                if (rsp_take) begin
                    slot_fill_q[fill_ptr_q] <= 1'b1;
                    slot_inst_q[fill_ptr_q] <= memRspData;
                end
            end
            if (accept) begin
                slot_pc_q[alloc_idx]   <= req_pc;
                slot_fill_q[alloc_idx] <= 1'b0;
            end
        end
    end

    assign memReqAddr   = req_pc;
    assign pcOut        = pc_out_q;
    assign pcPlusOut    = pc_plus_q;
    assign instOut      = inst_out_q;
    assign instValidOut = valid_out_q;
    assign bufCount     = alloc_cnt_q;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench for stage_if_prefetch with an in-order memory model
// returning inst = 0x1000 + addr after a programmable latency.
module tb_stage_if_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        jumpEn = 1'b0;
    logic [31:0] jumpAddr = '0;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic [31:0] memReqAddr;
    logic        memRspValid = 1'b0;
    logic [31:0] memRspData = '0;
    logic [31:0] pcOut, pcPlusOut, instOut;
    logic        instValidOut;
    logic [2:0]  bufCount;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int cyc = 0;
    int rsp_cnt = 0;
    logic [31:0] q_addr[$];
    int          q_t[$];

    stage_if_prefetch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr),
        .memRspValid(memRspValid), .memRspData(memRspData),
        .pcOut(pcOut), .pcPlusOut(pcPlusOut), .instOut(instOut),
        .instValidOut(instValidOut), .bufCount(bufCount)
    );

    always #5 clk = ~clk;

    // in-order memory: request accepted at edge t is presented once t+lat-1 is reached
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            q_addr.delete();
            q_t.delete();
            memRspValid <= 1'b0;
        end else begin
            if (memReqValid && memReqReady) begin
                q_addr.push_back(memReqAddr);
                q_t.push_back(cyc);
            end
            if (q_t.size() > 0 && q_t[0] + lat - 1 <= cyc) begin
                memRspValid <= 1'b1;
                memRspData  <= 32'h1000 + q_addr[0];
                rsp_cnt     <= rsp_cnt + 1;
                void'(q_addr.pop_front());
                void'(q_t.pop_front());
            end else begin
                memRspValid <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        jumpEn = 1'b0;
        jumpAddr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        lat = 1;
        memReqReady = 1'b1;
        do_reset();
        @(negedge clk);
        checks++;
        if (instValidOut !== 1'b0 || bufCount !== 3'd1) begin
            errors++;
            $display("FAIL free_first: v=%b cnt=%0d want v=0 cnt=1", instValidOut, bufCount);
        end
        @(negedge clk);
        checks++;
        if (instValidOut !== 1'b0) begin
            errors++;
            $display("FAIL free_lat: v=%b want 0", instValidOut);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b1 || pcOut !== 32'(k) || pcPlusOut !== 32'(k + 1)
                || instOut !== 32'h1000 + 32'(k)) begin
                errors++;
                $display("FAIL free_stream k=%0d: v=%b pc=%h pp=%h inst=%h want pc=%h",
                         k, instValidOut, pcOut, pcPlusOut, instOut, k);
            end
        end
        checks++;
        if (bufCount !== 3'd2) begin
            errors++;
            $display("FAIL free_count: cnt=%0d want 2", bufCount);
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pcOut !== 32'h0 || pcPlusOut !== 32'h0 || instOut !== 32'h13
            || instValidOut !== 1'b0 || bufCount !== 3'd0) begin
            errors++;
            $display("FAIL reset_out: pc=%h pp=%h inst=%h v=%b cnt=%0d want bubble",
                     pcOut, pcPlusOut, instOut, instValidOut, bufCount);
        end
        checks++;
        if (memReqValid !== 1'b1 || memReqAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: rv=%b addr=%h want rv=1 addr=0", memReqValid, memReqAddr);
        end
    endtask

    task automatic test_not_ready();
        int base;
        lat = 1;
        memReqReady = 1'b0;
        do_reset();
        base = rsp_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (memReqAddr !== 32'h0 || memReqValid !== 1'b1 || instValidOut !== 1'b0
                || bufCount !== 3'd0) begin
                errors++;
                $display("FAIL noready k=%0d: addr=%h rv=%b v=%b cnt=%0d want 0/1/0/0",
                         k, memReqAddr, memReqValid, instValidOut, bufCount);
            end
        end
        checks++;
        if (rsp_cnt !== base) begin
            errors++;
            $display("FAIL noready_rsp: rsp=%0d want %0d", rsp_cnt, base);
        end
        memReqReady = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (instValidOut !== 1'b1 || pcOut !== 32'h0 || instOut !== 32'h1000) begin
            errors++;
            $display("FAIL noready_go: v=%b pc=%h inst=%h want 1/0/1000",
                     instValidOut, pcOut, instOut);
        end
    endtask

    task automatic test_stall();
        lat = 1;
        memReqReady = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b1 || pcOut !== 32'h0 || instOut !== 32'h1000) begin
                errors++;
                $display("FAIL stall_hold k=%0d: v=%b pc=%h inst=%h want 1/0/1000",
                         k, instValidOut, pcOut, instOut);
            end
        end
        checks++;
        if (bufCount !== 3'd4 || memReqValid !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: cnt=%0d rv=%b want 4/0", bufCount, memReqValid);
        end
        stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b1 || pcOut !== 32'(k) || instOut !== 32'h1000 + 32'(k)) begin
                errors++;
                $display("FAIL stall_drain k=%0d: v=%b pc=%h inst=%h", k, instValidOut, pcOut, instOut);
            end
        end
    endtask

    task automatic test_flush();
        lat = 1;
        memReqReady = 1'b1;
        do_reset();
        repeat (7) @(negedge clk);
        checks++;
        if (pcOut !== 32'h4 || instValidOut !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: pc=%h v=%b want 4/1", pcOut, instValidOut);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (instValidOut !== 1'b0 || pcOut !== 32'h0 || instOut !== 32'h13) begin
            errors++;
            $display("FAIL flush_bubble: v=%b pc=%h inst=%h want bubble", instValidOut, pcOut, instOut);
        end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b1 || pcOut !== 32'(k) || instOut !== 32'h1000 + 32'(k)) begin
                errors++;
                $display("FAIL flush_resume k=%0d: v=%b pc=%h inst=%h", k, instValidOut, pcOut, instOut);
            end
        end
    endtask

    task automatic test_jump();
        lat = 3;
        memReqReady = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b0) begin
                errors++;
                $display("FAIL jump_pre k=%0d: v=%b want 0", k, instValidOut);
            end
        end
        jumpEn = 1'b1;
        jumpAddr = 32'h40;
        @(negedge clk);
        jumpEn = 1'b0;
        checks++;
        if (instValidOut !== 1'b0 || bufCount !== 3'd1) begin
            errors++;
            $display("FAIL jump_redirect: v=%b cnt=%0d want 0/1", instValidOut, bufCount);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b0) begin
                errors++;
                $display("FAIL jump_drop k=%0d: v=%b pc=%h want bubble", k, instValidOut, pcOut);
            end
        end
        @(negedge clk);
        checks++;
        if (instValidOut !== 1'b1 || pcOut !== 32'h40 || pcPlusOut !== 32'h41
            || instOut !== 32'h1040) begin
            errors++;
            $display("FAIL jump_first: v=%b pc=%h pp=%h inst=%h want 40/41/1040",
                     instValidOut, pcOut, pcPlusOut, instOut);
        end
        @(negedge clk);
        checks++;
        if (instValidOut !== 1'b1 || pcOut !== 32'h41 || instOut !== 32'h1041) begin
            errors++;
            $display("FAIL jump_second: v=%b pc=%h inst=%h want 41/1041", instValidOut, pcOut, instOut);
        end
    endtask

    task automatic test_jump_at(input logic [31:0] tgt);
        lat = 1;
        memReqReady = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        jumpEn = 1'b1;
        jumpAddr = tgt;
        @(negedge clk);
        jumpEn = 1'b0;
        checks++;
        if (instValidOut !== 1'b0 || bufCount !== 3'd1) begin
            errors++;
            $display("FAIL samecyc_redirect: v=%b cnt=%0d want 0/1", instValidOut, bufCount);
        end
        @(negedge clk);
        checks++;
        if (instValidOut !== 1'b0) begin
            errors++;
            $display("FAIL samecyc_lat: v=%b want 0", instValidOut);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (instValidOut !== 1'b1 || pcOut !== tgt + 32'(k)
                || pcPlusOut !== tgt + 32'(k + 1) || instOut !== 32'h1000 + tgt + 32'(k)) begin
                errors++;
                $display("FAIL samecyc_stream k=%0d: v=%b pc=%h pp=%h inst=%h want pc=%h",
                         k, instValidOut, pcOut, pcPlusOut, instOut, tgt + 32'(k));
            end
        end
    endtask

    initial begin
        test_free_run();
        test_reset();
        test_not_ready();
        test_stall();
        test_flush();
        test_jump();
        test_jump_at(32'h80);
        test_jump_at(32'hFFFF_FFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
